// File: rtl/banked_ram_ctrl.sv
// ---------------------------------------------------------------------------
// banked_ram_ctrl
//
// Purpose:
//   NUM_BANKS synchronous RAM banks (DEPTH x WIDTH each) behind one flat
//   address space. The upper address bits pick a bank through a one-hot
//   decoder and the lower bits index the word. One request is outstanding
//   at a time: IDLE -> ACCESS -> RESP -> IDLE. A response is a one-cycle
//   pulse with no backpressure. Bank read data is merged with AND-OR, so
//   no tri-state buses are used.
//
// Optional feature (macro BANKED_RAM_PARITY_EN):
//   When the macro is defined, each word stores an extra even-parity bit.
//   The parity is checked on reads, and the extra output parity_err
//   pulses together with rsp_valid when the check fails.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   req_valid  in   1          request present
//   req_ready  out  1          request can be accepted (IDLE only)
//   req_rw     in   1          1 = read, 0 = write
//   req_addr   in   ADDR_W     {bank field, word index}
//   req_wdata  in   WIDTH      write data
//   rsp_valid  out  1          one-cycle response pulse
//   rsp_rdata  out  WIDTH      read data (0 on writes / errors)
//   rsp_err    out  1          bank field >= NUM_BANKS
//   bank_sel   out  NUM_BANKS  one-hot bank of the captured request
//   parity_err out  1          (BANKED_RAM_PARITY_EN only) read parity mismatch
// ---------------------------------------------------------------------------
module banked_ram_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 1024,
    parameter int NUM_BANKS = 2,
    localparam int BANK_AW  = $clog2(DEPTH),
    localparam int SEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int ADDR_W   = BANK_AW + SEL_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rw,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 rsp_valid,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic                 rsp_err,
`ifdef BANKED_RAM_PARITY_EN
    output logic                 parity_err,
`endif
    output logic [NUM_BANKS-1:0] bank_sel
);

`ifdef BANKED_RAM_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    // One extra bit so that NUM_BANKS == 2**SEL_W still fits.
    localparam logic [SEL_W:0] NB = (SEL_W + 1)'(NUM_BANKS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic                 rw_reg;
    logic [BANK_AW-1:0]   word_reg;
    logic [WIDTH-1:0]     wdata_reg;
    logic                 err_reg;
    logic [NUM_BANKS-1:0] bank_sel_reg;

    logic                 handshake;
    logic [SEL_W-1:0]     bank_field;
    logic                 addr_err;
    logic [NUM_BANKS-1:0] dec_onehot;
    logic [MW-1:0]        wr_word;

    logic [NUM_BANKS-1:0][MW-1:0] bank_rd;
    logic [MW-1:0]                merged_rd;

    assign req_ready  = (state_reg == IDLE);
    assign handshake  = req_valid && req_ready;
    assign bank_field = req_addr[ADDR_W-1:BANK_AW];
    assign addr_err   = !({1'b0, bank_field} < NB);
    assign bank_sel   = bank_sel_reg;

`ifdef BANKED_RAM_PARITY_EN
    // The stored parity bit makes the total number of ones even.
    assign wr_word = {^wdata_reg, wdata_reg};
`else
    assign wr_word = wdata_reg;
`endif

    // One-hot bank decoder.
    // Out-of-range bank fields match no bit; they are also masked below.
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_dec
        assign dec_onehot[gi] = (bank_field == SEL_W'(gi));
    end

    // Memory banks.
    // Each bank is a plain array with a registered read, so it maps to block
    // RAM. The bank arrays are not reset. A bank whose bank_sel bit is clear
    // sees no access at all; that covers both unselected banks and the
    // error case.
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [MW-1:0] mem [DEPTH];
        logic [MW-1:0] rd_reg;

        always_ff @(posedge clk) begin
            if (state_reg == ACCESS && bank_sel_reg[gi]) begin
                if (rw_reg) begin
                    rd_reg <= mem[word_reg];
                end else begin
                    mem[word_reg] <= wr_word;
                end
            end
        end

        assign bank_rd[gi] = rd_reg & {MW{bank_sel_reg[gi]}};
    end

    always_comb begin
        merged_rd = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            merged_rd = merged_rd | bank_rd[i];
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (handshake) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and response registers.
    // The response is registered on the edge that leaves RESP. As a result,
    // the pulse appears in the first IDLE cycle, two edges after the
    // handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rw_reg       <= 1'b0;
            word_reg     <= '0;
            wdata_reg    <= '0;
            err_reg      <= 1'b0;
            bank_sel_reg <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
`ifdef BANKED_RAM_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef BANKED_RAM_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        rw_reg       <= req_rw;
                        word_reg     <= req_addr[BANK_AW-1:0];
                        wdata_reg    <= req_wdata;
                        err_reg      <= addr_err;
                        bank_sel_reg <= addr_err ? '0 : dec_onehot;
                    end
                end
                RESP: begin
                    rsp_valid    <= 1'b1;
                    rsp_err      <= err_reg;
                    bank_sel_reg <= '0;
                    if (rw_reg && !err_reg) begin
                        rsp_rdata <= merged_rd[WIDTH-1:0];
`ifdef BANKED_RAM_PARITY_EN
                        parity_err <= ^merged_rd;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_banked_ram_ctrl.sv
module tb_banked_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_rw;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        use3;

    // Instance with two banks (11-bit address).
    logic       rdy2, rv2, err2;
    logic [7:0] rd2;
    logic [1:0] bs2;
    // Instance with three banks (12-bit address, bank field 3 is out of range).
    logic       rdy3, rv3, err3;
    logic [7:0] rd3;
    logic [2:0] bs3;
`ifdef BANKED_RAM_PARITY_EN
    logic       pe2, pe3;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    banked_ram_ctrl #(.WIDTH(8), .DEPTH(1024), .NUM_BANKS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~use3), .req_ready(rdy2),
        .req_rw(req_rw), .req_addr(req_addr[10:0]), .req_wdata(req_wdata),
        .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(err2),
`ifdef BANKED_RAM_PARITY_EN
        .parity_err(pe2),
`endif
        .bank_sel(bs2)
    );

    banked_ram_ctrl #(.WIDTH(8), .DEPTH(1024), .NUM_BANKS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & use3), .req_ready(rdy3),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3),
`ifdef BANKED_RAM_PARITY_EN
        .parity_err(pe3),
`endif
        .bank_sel(bs3)
    );

    // Outputs of whichever instance is under test.
    logic       ready, rsp_valid, rsp_err, par;
    logic [7:0] rsp_rdata;
    logic [2:0] sel;
    assign ready     = use3 ? rdy3 : rdy2;
    assign rsp_valid = use3 ? rv3 : rv2;
    assign rsp_err   = use3 ? err3 : err2;
    assign rsp_rdata = use3 ? rd3 : rd2;
    assign sel       = use3 ? bs3 : {1'b0, bs2};
`ifdef BANKED_RAM_PARITY_EN
    assign par = use3 ? pe3 : pe2;
`else
    assign par = 1'b0;
`endif

    typedef struct {
        logic        use3;
        logic        rw;
        logic [11:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        logic        err;
        logic        par;
        logic [2:0]  sel;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic u, input logic rw, input logic [11:0] a,
                                input logic [7:0] wd, input logic [7:0] rd,
                                input logic err, input logic p, input logic [2:0] s);
        vec_t v;
        v.use3 = u; v.rw = rw; v.addr = a; v.wd = wd; v.rd = rd;
        v.err = err; v.par = p; v.sel = s;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Runs one full transaction.
    // Latency is counted in rising edges after the handshake edge.
    task automatic txn(input vec_t v, input string nm);
        int lat;
        use3 = v.use3;
        @(negedge clk);
        chk({nm, " ready_idle"}, 32'(ready), 32'd1);
        req_valid = 1'b1;
        req_rw    = v.rw;
        req_addr  = v.addr;
        req_wdata = v.wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk({nm, " bank_sel_access"}, 32'(sel), 32'(v.sel));
        chk({nm, " ready_busy"}, 32'(ready), 32'd0);
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'd2);
        if (lat != 0) begin
            chk({nm, " rdata"}, 32'(rsp_rdata), 32'(v.rd));
            chk({nm, " err"}, 32'(rsp_err), 32'(v.err));
            chk({nm, " parity_err"}, 32'(par), 32'(v.par));
            chk({nm, " bank_sel_cleared"}, 32'(sel), 32'd0);
        end
        $display("txn %s rw=%0d addr=%03h wd=%02h -> rdata=%02h err=%0d lat=%0d",
                 nm, v.rw, v.addr, v.wd, rsp_rdata, rsp_err, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        vecs[0]  = mk(0, 0, 12'h001, 8'hAC, 8'h00, 0, 0, 3'b001);
        vecs[1]  = mk(0, 1, 12'h001, 8'h00, 8'hAC, 0, 0, 3'b001);
        vecs[2]  = mk(0, 0, 12'h401, 8'h5A, 8'h00, 0, 0, 3'b010);
        vecs[3]  = mk(0, 1, 12'h001, 8'h00, 8'hAC, 0, 0, 3'b001);
        vecs[4]  = mk(0, 1, 12'h401, 8'h00, 8'h5A, 0, 0, 3'b010);
        vecs[5]  = mk(0, 0, 12'h3FF, 8'h11, 8'h00, 0, 0, 3'b001);
        vecs[6]  = mk(0, 0, 12'h400, 8'h22, 8'h00, 0, 0, 3'b010);
        vecs[7]  = mk(0, 1, 12'h3FF, 8'h00, 8'h11, 0, 0, 3'b001);
        vecs[8]  = mk(0, 1, 12'h400, 8'h00, 8'h22, 0, 0, 3'b010);
        vecs[9]  = mk(0, 0, 12'h001, 8'hC3, 8'h00, 0, 0, 3'b001);
        vecs[10] = mk(0, 1, 12'h001, 8'h00, 8'hC3, 0, 0, 3'b001);
        vecs[11] = mk(0, 0, 12'h002, 8'h55, 8'h00, 0, 0, 3'b001);
        vecs[12] = mk(1, 0, 12'h005, 8'h10, 8'h00, 0, 0, 3'b001);
        vecs[13] = mk(1, 0, 12'h405, 8'h20, 8'h00, 0, 0, 3'b010);
        vecs[14] = mk(1, 0, 12'h805, 8'h30, 8'h00, 0, 0, 3'b100);
        vecs[15] = mk(1, 1, 12'h805, 8'h00, 8'h30, 0, 0, 3'b100);

        use3 = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset rsp_valid", 32'({rv2, rv3}), 32'd0);
        chk("reset rsp_rdata", 32'({rd2, rd3}), 32'd0);
        chk("reset rsp_err", 32'({err2, err3}), 32'd0);
        chk("reset bank_sel", 32'({bs2, bs3}), 32'd0);
        chk("reset req_ready", 32'({rdy2, rdy3}), 32'b11);
        chk("reset parity_err", 32'(par), 32'd0);

        for (int i = 0; i < 12; i++) txn(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted in the middle of ACCESS. The pending write of 0x77
        // must not land, and no response may be emitted.
        use3 = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h002; req_wdata = 8'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("midreset in_access", 32'(ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset outputs", 32'({rsp_valid, rsp_rdata, rsp_err, sel}), 32'd0);
        chk("midreset ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) pulses++;
        end
        chk("midreset no_response", 32'(pulses), 32'd0);
        txn(mk(0, 1, 12'h002, 8'h00, 8'h55, 0, 0, 3'b001), "midreset readback");

        for (int i = 12; i < 16; i++) txn(vecs[i], $sformatf("vec%0d", i));

        // Out-of-range bank with req_valid held through ACCESS and RESP.
        use3 = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'hC05; req_wdata = 8'h99;
        @(posedge clk);
        #1;
        chk("oor access ready", 32'(ready), 32'd0);
        chk("oor access bank_sel", 32'(sel), 32'd0);
        @(posedge clk);
        #1;
        chk("oor resp ready", 32'(ready), 32'd0);
        chk("oor early rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("oor rsp_valid", 32'(rsp_valid), 32'd1);
        chk("oor rsp_err", 32'(rsp_err), 32'd1);
        chk("oor rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("oor back_idle", 32'(ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) pulses++;
        end
        chk("oor single_handshake", 32'(pulses), 32'd0);
        $display("txn oor addr=C05 wd=99 -> err=1 handshakes=1");
        txn(mk(1, 1, 12'h005, 8'h00, 8'h10, 0, 0, 3'b001), "oor bank0_intact");
        txn(mk(1, 1, 12'h405, 8'h00, 8'h20, 0, 0, 3'b010), "oor bank1_intact");
        txn(mk(1, 1, 12'h805, 8'h00, 8'h30, 0, 0, 3'b100), "oor bank2_intact");

`ifdef BANKED_RAM_PARITY_EN
        // Flip data bit 0 of the stored word at 0x001 (0xC3). The parity bit is not
        // updated, so the read should return 0xC2 and flag parity_err.
        use3 = 1'b0;
        @(negedge clk);
        dut2.g_bank[0].mem[1] = dut2.g_bank[0].mem[1] ^ 9'h001;
        txn(mk(0, 1, 12'h001, 8'h00, 8'hC2, 0, 1, 3'b001), "parity corrupt");
        txn(mk(0, 1, 12'h401, 8'h00, 8'h5A, 0, 0, 3'b010), "parity clean");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
